rx_fifo_reader: RTL and testbench
=================================

# rx_fifo_reader

Read-side controller for the RX PCS elastic FIFO. It runs in the read clock domain and drains 72-bit XGMII words from the dual-port FIFO memory into the RX XGMII output register. It owns the read pointer and the empty flag. It also performs rate compensation: idle words are emitted when the FIFO is empty between frames, and the rest of a frame is error-poisoned if the FIFO underflows mid-frame.

## Interface
- `DATASIZE`, 72: word width, `[71:64]` = ctrl lanes 7..0, `[63:0]` = data, lane i = bits `[8i+7:8i]`
- `ADDRSIZE`, 7: FIFO address bits, depth = 2^ADDRSIZE

- `rclk` in 1: read clock; the single clock of this block
- `rrst` in 1: synchronous, active-high reset
- `rq2_wptr` in ADDRSIZE+1: Gray write pointer, already synchronized into `rclk`
- `rdata` in DATASIZE: memory read data; combinational from `raddr`
- `raddr` out ADDRSIZE: memory read address
- `rptr` out ADDRSIZE+1: registered Gray read pointer, sent to the write-domain synchronizer
- `rempty` out 1: FIFO empty, registered
- `rd_en` in 1: downstream requests one output word this cycle
- `xgmii_rxd` out 64: output data, registered
- `xgmii_rxc` out 8: output control, registered
- `uf_count` out 16: mid-frame underflow events, saturating

## Operation
- **Pointers (Cummings style).**
  - `rbin` is binary, ADDRSIZE+1 bits.
  - `pop = rd_en & !rempty`.
  - `rbinnext = rbin + pop`.
  - `rgraynext = (rbinnext>>1) ^ rbinnext`.
  - `raddr = rbin[ADDRSIZE-1:0]`.
  - `rptr <= rgraynext`.
  - `rempty <= (rgraynext == rq2_wptr)`.
- **Character codes.**
  - Start = lane0 0xFB with ctrl=1.
  - Terminate = any lane 0xFD with ctrl=1.
  - IDLE_WORD = rxd 0x0707070707070707, rxc 0xFF.
  - ERROR_WORD = rxd 0xFEFEFEFEFEFEFEFE, rxc 0xFF.
- **FSM states:** IDLE (between frames), FRAME (inside frame), POISON (frame corrupted by underflow).
- **Per cycle with `rd_en`=1:**
  - IDLE, pop: output `rdata`. If the word has Start and no Terminate, go to FRAME; otherwise stay in IDLE.
  - IDLE, empty: output IDLE_WORD; no pop; stay in IDLE.
  - FRAME, pop: output `rdata`. If the word has Terminate, go to IDLE.
  - FRAME, empty: output ERROR_WORD, increment `uf_count`, go to POISON.
  - POISON, pop: output ERROR_WORD. If the popped word has Terminate, go to IDLE.
  - POISON, empty: output ERROR_WORD; stay in POISON; no further count.
- **`rd_en`=0:** no pop; outputs, state and pointers hold.
- **`uf_count`:** saturates at 0xFFFF.

## Timing
- **Reset values:**
  - `rbin` = `rptr` = `raddr` = 0, `rempty` = 1.
  - Outputs = IDLE_WORD, state IDLE, `uf_count` = 0.
- **Read latency:** `rdata` is sampled in the `rd_en` cycle; `xgmii_rxd`/`xgmii_rxc` are valid the next edge (1 cycle).
- **Pointer update:** `rempty` and `rptr` update on the same edge as the pop.
- **Back-to-back pops:** one word per cycle, sustained.
- **Empty detection:** `rempty` deasserts one cycle after `rq2_wptr` changes.
- **Simultaneous last pop and write arrival:** `rempty` is computed from the new `rgraynext` against the current `rq2_wptr`. It may stay conservatively 1 for one cycle; it must never read a stale word.
- **Wrap-around:** `raddr` wraps from 2^ADDRSIZE-1 to 0; the `rbin` MSB toggles. Full-lap pointer equality means empty only when the Gray values match.
- **Reset mid-frame:** the next edge returns to reset values; the partial frame is abandoned without an error word.

## Structure
- **Package `pcs_rx_pkg`:**
  - XGMII character constants: START 0xFB, TERM 0xFD, IDLE 0x07, ERROR 0xFE.
  - IDLE_WORD and ERROR_WORD.
  - Read FSM state enum: IDLE, FRAME, POISON.
- **Sub-module `rptr_empty`:** binary/Gray read pointer, `raddr`, `rptr` and registered `rempty`. Parameter ADDRSIZE; ports `rclk`, `rrst`, `pop` in.
- **Top level:** framing FSM, output register, underflow counter.

## Test plan
- **Reset:** assert `rrst` 2 cycles → `xgmii_rxd`=0x0707070707070707, `xgmii_rxc`=0xFF, `rempty`=1, `rptr`=0, `uf_count`=0.
- **Three-word frame:** preload Start word / data word 0x1122334455667788 rxc 0x00 / Terminate word; advance `rq2_wptr` to Gray(3); `rd_en`=1 for 3 cycles → three words appear in order, each 1 cycle after its pop. `rempty`=1 after the third pop, `rptr`=Gray(3), FSM in IDLE.
- **Idle fill:** empty FIFO, state IDLE, `rd_en`=1 for 5 cycles → IDLE_WORD each cycle, `rptr` unchanged, `uf_count`=0.
- **Mid-frame underflow:** pop Start word only; FIFO empty with `rd_en`=1 → ERROR_WORD, `uf_count`=1. Then supply 2 data words and a Terminate word → all three are output as ERROR_WORD. Next empty cycle → IDLE_WORD.
- **Wrap:** stream 300 words through (depth 128) → `raddr` wraps 127→0 twice, `rptr` Gray MSB toggles, no false empty or missed word.
- **Stall and reset:**
  - `rd_en`=0 mid-frame for 4 cycles → outputs hold and pointers unchanged.
  - `rrst` asserted mid-frame → IDLE_WORD, `rptr`=0 on the next edge.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared XGMII character codes, word layout and read-side FSM state type
// for the RX PCS elastic FIFO.
package pcs_rx_pkg;

  localparam int unsigned XGMII_LANES  = 8;
  localparam int unsigned XGMII_DATA_W = 64;
  localparam int unsigned XGMII_CTRL_W = 8;
  localparam int unsigned XGMII_WORD_W = XGMII_DATA_W + XGMII_CTRL_W;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  // Ctrl lanes occupy the top byte so the struct matches the FIFO word layout.
  typedef struct packed {
    logic [XGMII_CTRL_W-1:0] rxc;
    logic [XGMII_DATA_W-1:0] rxd;
  } xgmii_word_t;

  localparam xgmii_word_t IDLE_WORD  = '{rxc: 8'hFF, rxd: {XGMII_LANES{XGMII_IDLE}}};
  localparam xgmii_word_t ERROR_WORD = '{rxc: 8'hFF, rxd: {XGMII_LANES{XGMII_ERROR}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_POISON = 2'd2
  } rd_state_e;

  function automatic logic has_start(input xgmii_word_t w);
    return w.rxc[0] && (w.rxd[7:0] == XGMII_START);
  endfunction

  function automatic logic has_term(input xgmii_word_t w);
    logic v_hit;
    v_hit = 1'b0;
    for (int i = 0; i < int'(XGMII_LANES); i++) begin
      if (w.rxc[i] && (w.rxd[8*i +: 8] == XGMII_TERM)) v_hit = 1'b1;
    end
    return v_hit;
  endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read pointer and empty flag of the elastic FIFO: binary/Gray read pointer,
// memory read address and registered empty.
module rptr_empty #(
  parameter int unsigned ADDRSIZE = 7
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                pop,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] r_rptr;
  logic             r_rempty;
  logic [PTR_W-1:0] w_rbinnext;
  logic [PTR_W-1:0] w_rgraynext;

  assign w_rbinnext  = r_rbin + PTR_W'(pop);
  assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

  // Empty is judged on the post-pop Gray pointer, so a word is never read stale.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinnext;
      r_rptr   <= w_rgraynext;
      r_rempty <= (w_rgraynext == rq2_wptr);
    end
  end

  assign raddr  = r_rbin[ADDRSIZE-1:0];
  assign rptr   = r_rptr;
  assign rempty = r_rempty;

endmodule

// File: rtl/rx_fifo_reader.sv
// Read-side controller for the RX PCS elastic FIFO: drains words into the
// XGMII output register, fills idles when empty and poisons underflowed frames.
module rx_fifo_reader
  import pcs_rx_pkg::*;
#(
  parameter int unsigned DATASIZE = 72,
  parameter int unsigned ADDRSIZE = 7
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  input  logic                rd_en,
  output logic [63:0]         xgmii_rxd,
  output logic [7:0]          xgmii_rxc,
  output logic [15:0]         uf_count
);

  localparam int unsigned UF_W = 16;

  rd_state_e   r_state;
  rd_state_e   w_state_next;
  xgmii_word_t r_out;
  xgmii_word_t w_out;
  xgmii_word_t w_word;
  logic        w_pop;
  logic        w_uf_inc;
  logic        w_start;
  logic        w_term;
  logic [UF_W-1:0] r_uf_count;

  assign w_word  = rdata;
  assign w_pop   = rd_en & ~rempty;
  assign w_start = has_start(w_word);
  assign w_term  = has_term(w_word);

  rptr_empty #(
    .ADDRSIZE (ADDRSIZE)
  ) u_rptr_empty (
    .rclk     (rclk),
    .rrst     (rrst),
    .pop      (w_pop),
    .rq2_wptr (rq2_wptr),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty)
  );

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state    <= ST_IDLE;
      r_out      <= IDLE_WORD;
      r_uf_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out;
      if (w_uf_inc && (r_uf_count != {UF_W{1'b1}})) begin
        r_uf_count <= r_uf_count + UF_W'(1);
      end
    end
  end

  // Framing FSM: everything holds when rd_en is low.
  always_comb begin
    w_state_next = r_state;
    w_out        = r_out;
    w_uf_inc     = 1'b0;
    if (rd_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            w_out = w_word;
            if (w_start && !w_term) w_state_next = ST_FRAME;
          end else begin
            w_out = IDLE_WORD;
          end
        end
        ST_FRAME: begin
          if (w_pop) begin
            w_out = w_word;
            if (w_term) w_state_next = ST_IDLE;
          end else begin
            w_out        = ERROR_WORD;
            w_uf_inc     = 1'b1;
            w_state_next = ST_POISON;
          end
        end
        ST_POISON: begin
          w_out = ERROR_WORD;
          if (w_pop && w_term) w_state_next = ST_IDLE;
        end
        default: begin
          w_out        = IDLE_WORD;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign xgmii_rxd = r_out.rxd;
  assign xgmii_rxc = r_out.rxc;
  assign uf_count  = r_uf_count;

endmodule

// File: tb/tb_rx_fifo_reader.sv
// Self-checking bench for rx_fifo_reader: FIFO memory and write pointer are
// modelled here, outputs checked against a queue-based framing model.
module tb_rx_fifo_reader;

  localparam int unsigned DEPTH = 128;
  localparam logic [71:0] T_IDLE = {8'hFF, {8{8'h07}}};
  localparam logic [71:0] T_ERR  = {8'hFF, {8{8'hFE}}};

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rd_en;
  logic [7:0]  rq2_wptr;
  logic [71:0] rdata;
  logic [6:0]  raddr;
  logic [7:0]  rptr;
  logic        rempty;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [15:0] uf_count;

  logic [71:0] mem [DEPTH];
  assign rdata = mem[raddr];

  always #5 rclk = ~rclk;

  rx_fifo_reader dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .rdata     (rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rd_en     (rd_en),
    .xgmii_rxd (xgmii_rxd),
    .xgmii_rxc (xgmii_rxc),
    .uf_count  (uf_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [71:0] q[$];
  logic [71:0] pending[$];
  bit          m_in_frame;
  bit          m_poisoned;
  int unsigned m_uf;
  int unsigned m_pops;
  int unsigned m_wr;
  logic [71:0] m_last;

  function automatic logic [7:0] gray8(input int unsigned b);
    logic [7:0] x;
    x = 8'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic bit is_start(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic bit is_term(input logic [71:0] w);
    for (int i = 0; i < 8; i++) if (w[64+i] && (w[8*i +: 8] == 8'hFD)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_in_frame = 1'b0;
    m_poisoned = 1'b0;
    m_uf = 0;
    m_pops = 0;
    m_wr = 0;
    m_last = T_IDLE;
    rq2_wptr = 8'h00;
  endfunction

  // Expected output word after one cycle with the given read enable.
  function automatic logic [71:0] model_step(input bit rd);
    logic [71:0] w;
    logic [71:0] o;
    if (!rd) return m_last;
    if (q.size() == 0) begin
      if (m_in_frame && !m_poisoned) begin
        m_poisoned = 1'b1;
        if (m_uf < 65535) m_uf++;
        o = T_ERR;
      end else if (m_poisoned) o = T_ERR;
      else o = T_IDLE;
    end else begin
      w = q.pop_front();
      m_pops++;
      if (m_poisoned) begin
        o = T_ERR;
        if (is_term(w)) begin m_poisoned = 1'b0; m_in_frame = 1'b0; end
      end else if (m_in_frame) begin
        o = w;
        if (is_term(w)) m_in_frame = 1'b0;
      end else begin
        o = w;
        if (is_start(w) && !is_term(w)) m_in_frame = 1'b1;
      end
    end
    m_last = o;
    return o;
  endfunction

  task automatic push(input logic [71:0] w);
    mem[m_wr % DEPTH] = w;
    m_wr++;
    rq2_wptr = gray8(m_wr);
    q.push_back(w);
  endtask

  function automatic logic [71:0] start_word();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[7:0] = 8'hFB;
    return {8'h01, d};
  endfunction

  function automatic logic [71:0] data_word();
    return {8'h00, $urandom, $urandom};
  endfunction

  function automatic logic [71:0] term_word();
    logic [71:0] w;
    int unsigned k;
    k = $urandom_range(0, 7);
    w = {8'h00, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      if (i == int'(k)) begin w[64+i] = 1'b1; w[8*i +: 8] = 8'hFD; end
      else if (i > int'(k)) begin w[64+i] = 1'b1; w[8*i +: 8] = 8'h07; end
    end
    return w;
  endfunction

  task automatic gen_frame(input int unsigned len);
    pending.push_back(start_word());
    for (int i = 0; i < int'(len) - 2; i++) pending.push_back(data_word());
    pending.push_back(term_word());
  endtask

  task automatic tick(input bit rd, output logic [71:0] exp);
    rd_en = rd;
    exp = model_step(rd);
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rd_en = 1'b0;
    rrst = 1'b1;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_IDLE) begin
      n_fail++; $display("FAIL reset_out: got %h expected %h", {xgmii_rxc, xgmii_rxd}, T_IDLE);
    end
    n_checks++;
    if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
    n_checks++;
    if (rptr !== 8'h00 || raddr !== 7'h00) begin
      n_fail++; $display("FAIL reset_ptr: got rptr %h raddr %h expected 0", rptr, raddr);
    end
    n_checks++;
    if (uf_count !== 16'h0) begin n_fail++; $display("FAIL reset_uf: got %h expected 0", uf_count); end
    rrst = 1'b0;
  endtask

  task automatic test_three_word_frame();
    logic [71:0] w[3];
    logic [71:0] exp;
    w[0] = start_word();
    w[1] = {8'h00, 64'h1122334455667788};
    w[2] = {8'hFF, {7{8'h07}}, 8'hFD};
    for (int i = 0; i < 3; i++) push(w[i]);
    tick(1'b0, exp);
    n_checks++;
    if (rempty !== 1'b0) begin n_fail++; $display("FAIL three_rempty_pre: got %b expected 0", rempty); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, exp);
      n_checks++;
      if ({xgmii_rxc, xgmii_rxd} !== w[i]) begin
        n_fail++; $display("FAIL three_word%0d: got %h expected %h", i, {xgmii_rxc, xgmii_rxd}, w[i]);
      end
    end
    n_checks++;
    if (rempty !== 1'b1 || rptr !== gray8(3)) begin
      n_fail++; $display("FAIL three_ptr: got rempty %b rptr %h expected 1 %h", rempty, rptr, gray8(3));
    end
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_IDLE) begin
      n_fail++; $display("FAIL three_after: got %h expected %h", {xgmii_rxc, xgmii_rxd}, T_IDLE);
    end
  endtask

  task automatic test_idle_fill();
    logic [71:0] exp;
    logic [7:0]  p0;
    p0 = gray8(m_pops);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, exp);
      n_checks++;
      if ({xgmii_rxc, xgmii_rxd} !== T_IDLE || rptr !== p0 || uf_count !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_fill%0d: got %h rptr %h uf %h expected %h rptr %h uf 0",
                 i, {xgmii_rxc, xgmii_rxd}, rptr, uf_count, T_IDLE, p0);
      end
    end
  endtask

  task automatic test_underflow();
    logic [71:0] exp;
    logic [71:0] s;
    s = start_word();
    push(s);
    tick(1'b0, exp);
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== s) begin
      n_fail++; $display("FAIL uf_start: got %h expected %h", {xgmii_rxc, xgmii_rxd}, s);
    end
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_ERR || uf_count !== 16'd1) begin
      n_fail++; $display("FAIL uf_error: got %h uf %0d expected %h uf 1", {xgmii_rxc, xgmii_rxd}, uf_count, T_ERR);
    end
    push(data_word()); push(data_word()); push(term_word());
    tick(1'b0, exp);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, exp);
      n_checks++;
      if ({xgmii_rxc, xgmii_rxd} !== T_ERR || uf_count !== 16'd1) begin
        n_fail++; $display("FAIL uf_poison%0d: got %h uf %0d expected %h uf 1", i, {xgmii_rxc, xgmii_rxd}, uf_count, T_ERR);
      end
    end
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_IDLE || uf_count !== 16'd1) begin
      n_fail++; $display("FAIL uf_recover: got %h uf %0d expected %h uf 1", {xgmii_rxc, xgmii_rxd}, uf_count, T_IDLE);
    end
  endtask

  task automatic test_wrap();
    logic [71:0] exp;
    logic [6:0]  prev;
    int unsigned streamed;
    int unsigned wraps;
    int unsigned errs;
    streamed = 0; wraps = 0; errs = 0;
    while (streamed < 300) begin
      while (pending.size() < 20) gen_frame($urandom_range(2, 8));
      while (pending.size() > 0) begin push(pending.pop_front()); streamed++; end
      tick(1'b0, exp);
      while (q.size() > 0 || errs == 0) begin
        prev = raddr;
        tick(1'b1, exp);
        if (prev == 7'd127 && raddr == 7'd0) wraps++;
        n_checks++;
        if ({xgmii_rxc, xgmii_rxd} !== exp || rptr !== gray8(m_pops) ||
            raddr !== 7'(m_pops) || rempty !== (q.size() == 0)) begin
          n_fail++;
          $display("FAIL wrap_word: got %h rptr %h raddr %h rempty %b expected %h rptr %h raddr %h rempty %b",
                   {xgmii_rxc, xgmii_rxd}, rptr, raddr, rempty, exp, gray8(m_pops), 7'(m_pops), q.size() == 0);
        end
        if (q.size() == 0) errs = 1;
      end
      errs = 0;
    end
    n_checks++;
    if (wraps < 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected >= 2", wraps); end
  endtask

  task automatic test_random();
    logic [71:0] exp;
    int unsigned npush;
    int unsigned nread;
    bit          rd;
    for (int it = 0; it < 400; it++) begin
      npush = (q.size() < 100) ? $urandom_range(0, 4) : 0;
      for (int k = 0; k < int'(npush); k++) begin
        if (pending.size() == 0) begin
          if ($urandom_range(0, 3) == 0) pending.push_back(T_IDLE);
          gen_frame($urandom_range(2, 10));
        end
        push(pending.pop_front());
      end
      if (npush > 0) tick(1'b0, exp);
      nread = $urandom_range(0, 5);
      for (int k = 0; k < int'(nread); k++) begin
        rd = ($urandom_range(0, 3) != 0);
        tick(rd, exp);
        n_checks++;
        if ({xgmii_rxc, xgmii_rxd} !== exp || uf_count !== 16'(m_uf) ||
            rptr !== gray8(m_pops) || rempty !== (q.size() == 0)) begin
          n_fail++;
          $display("FAIL random_it%0d: got %h uf %0d rptr %h rempty %b expected %h uf %0d rptr %h rempty %b",
                   it, {xgmii_rxc, xgmii_rxd}, uf_count, rptr, rempty, exp, m_uf, gray8(m_pops), q.size() == 0);
        end
      end
    end
  endtask

  task automatic test_stall_reset();
    logic [71:0] exp;
    logic [71:0] s;
    logic [71:0] d1;
    logic [7:0]  hold_ptr;
    logic [6:0]  hold_addr;
    // Close out whatever frame the random phase left open.
    pending.delete();
    push(term_word());
    tick(1'b0, exp);
    while (q.size() > 0) tick(1'b1, exp);
    s = start_word();
    d1 = data_word();
    push(s); push(d1); push(data_word());
    tick(1'b0, exp);
    tick(1'b1, exp);
    hold_ptr = rptr;
    hold_addr = raddr;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, exp);
      n_checks++;
      if ({xgmii_rxc, xgmii_rxd} !== s || rptr !== hold_ptr || raddr !== hold_addr) begin
        n_fail++;
        $display("FAIL stall%0d: got %h rptr %h raddr %h expected %h rptr %h raddr %h",
                 i, {xgmii_rxc, xgmii_rxd}, rptr, raddr, s, hold_ptr, hold_addr);
      end
    end
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== d1) begin
      n_fail++; $display("FAIL stall_resume: got %h expected %h", {xgmii_rxc, xgmii_rxd}, d1);
    end
    rd_en = 1'b0;
    rrst = 1'b1;
    model_reset();
    @(posedge rclk);
    #1;
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_IDLE || rptr !== 8'h00 || raddr !== 7'h00 ||
        rempty !== 1'b1 || uf_count !== 16'h0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h rptr %h raddr %h rempty %b uf %h expected %h 00 00 1 0",
               {xgmii_rxc, xgmii_rxd}, rptr, raddr, rempty, uf_count, T_IDLE);
    end
    rrst = 1'b0;
    tick(1'b1, exp);
    n_checks++;
    if ({xgmii_rxc, xgmii_rxd} !== T_IDLE || uf_count !== 16'h0) begin
      n_fail++; $display("FAIL post_reset: got %h uf %h expected %h uf 0", {xgmii_rxc, xgmii_rxd}, uf_count, T_IDLE);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = T_IDLE;
    rd_en = 1'b0;
    rrst = 1'b1;
    rq2_wptr = 8'h00;
    test_reset();
    test_three_word_frame();
    test_idle_fill();
    test_underflow();
    test_wrap();
    test_random();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
